instr_sequencer: RTL and testbench
==================================

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 The module SHALL have parameter INSTR_WIDTH, default 20, the width of one instruction word.
REQ-002 The module SHALL have parameter PROG_BITS, default 4, the program store address width (16 words).
REQ-003 The module SHALL have parameters ALU_HOLD 4, STORE_HOLD 3 and LOAD_HOLD 4, the cycles each instruction class is held (each >=1).
REQ-004 clk  input  1  clock; all state SHALL change on its rising edge.
REQ-005 rst  input  1  reset; asynchronous, active-low.
REQ-006 prog_we  input  1  program store write enable.
REQ-007 prog_addr  input  PROG_BITS  program store write address.
REQ-008 prog_data  input  INSTR_WIDTH  program store write data.
REQ-009 start  input  1  begin execution at address 0.
REQ-010 stop  input  1  abort execution.
REQ-011 instruction  output  INSTR_WIDTH  registered instruction driven to simple_cpu.
REQ-012 issue  output  1  one-cycle pulse in the first cycle a new instruction is driven.
REQ-013 busy  output  1  high while executing.
REQ-014 done  output  1  one-cycle pulse on program completion.
REQ-015 pc  output  PROG_BITS  address of the word currently driven.

Function
REQ-016 Class decode SHALL use bits [19:18]: 01 ALU (ALU_HOLD), 11 store (STORE_HOLD), 10 load (LOAD_HOLD), 00 halt.
REQ-017 The FSM SHALL have states IDLE, RUN and DONE.
REQ-018 IDLE: instruction=0, busy=0; a program write (prog_we high, start low) SHALL write prog_data to prog_addr on the edge.
REQ-019 Program writes SHALL be ignored while busy or when start is high in the same cycle.
REQ-020 In IDLE with start high: if word 0 is a halt, the FSM SHALL go to DONE; otherwise on that edge instruction<=word 0, pc<=0, hold counter<=hold-1, and the FSM SHALL go to RUN.
REQ-021 In RUN, busy=1 and the counter SHALL decrement each edge while nonzero.
REQ-022 When the counter is 0, on the next edge the next address pc+1 SHALL be examined: if it is a halt or pc is 2^PROG_BITS-1, instruction<=0 and the FSM SHALL go to DONE; otherwise instruction<=word(pc+1), pc<=pc+1, and the counter SHALL be reloaded.
REQ-023 Each instruction SHALL therefore be driven for exactly its hold count of consecutive cycles.
REQ-024 issue SHALL be high for exactly the first cycle of each driven instruction.
REQ-025 DONE SHALL last one cycle with done=1, busy=0 and instruction=0, then return to IDLE.
REQ-026 stop high in RUN SHALL force instruction<=0 and IDLE on the next edge without asserting done; stop SHALL have priority over advance.
REQ-027 start SHALL be ignored in RUN and DONE.
REQ-028 A halt word with nonzero low bits SHALL still be treated as a halt.

Reset
REQ-029 rst low SHALL immediately force IDLE, instruction=0, pc=0, counter=0, issue=0, busy=0 and done=0, including mid-instruction.
REQ-030 Program store contents SHALL NOT be reset.

Configuration
REQ-031 With macro SEQ_LOOP_EN defined, reaching the end of the store (pc=2^PROG_BITS-1) SHALL wrap to address 0 and continue (DONE if word 0 is a halt); a halt word SHALL still end execution.
REQ-032 Without SEQ_LOOP_EN, reaching the end of the store SHALL go to DONE as in REQ-022.

Verification
REQ-033 Load words 0..3 = 0x47000, 0x53000, 0x72001, 0x00000; pulse start -> instruction shows 0x47000 for 4 cycles, then 0x53000 for 4 cycles, then 0x72001 for 4 cycles; issue pulses 3 times; done pulses once; busy is high for 12 cycles.
REQ-034 Load word 0 = 0xD80F0 and word 1 = 0xB80F0, with word 2 = 0 -> store held 3 cycles, then load held 4 cycles, then done.
REQ-035 Word 0 = 0x00005, then start -> no issue pulse, done one cycle after start, instruction stays 0.
REQ-036 Assert stop during the second cycle of 0x47000 -> instruction returns to 0 next cycle, busy low, done never pulses; a subsequent start restarts at pc=0.
REQ-037 Drive rst low mid-instruction, and separately attempt a prog_we write while busy -> all outputs are 0 immediately on reset, and the stored word is unchanged.
REQ-038 Fill all 16 words with 0x47000 -> without SEQ_LOOP_EN, done after 64 cycles; with SEQ_LOOP_EN, pc wraps 15->0 and busy stays high until stop.

Source files
------------

// File: rtl/instr_sequencer.sv
// Program store plus a three-state sequencer that feeds instructions to simple_cpu,
// holding each word for its class-dependent cycle count. Define SEQ_LOOP_EN to wrap at end of store.
module instr_sequencer #(
    parameter int INSTR_WIDTH = 20,
    parameter int PROG_BITS   = 4,
    parameter int ALU_HOLD    = 4,
    parameter int STORE_HOLD  = 3,
    parameter int LOAD_HOLD   = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   prog_we,
    input  logic [PROG_BITS-1:0]   prog_addr,
    input  logic [INSTR_WIDTH-1:0] prog_data,
    input  logic                   start,
    input  logic                   stop,
    output logic [INSTR_WIDTH-1:0] instruction,
    output logic                   issue,
    output logic                   busy,
    output logic                   done,
    output logic [PROG_BITS-1:0]   pc
);

    localparam int DEPTH = 1 << PROG_BITS;
    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    // Hold count minus one, so the counter reaching zero marks the last held cycle.
    function automatic logic [CNT_W-1:0] hold_of(input logic [1:0] cls);
        case (cls)
            2'b01:   hold_of = CNT_W'(ALU_HOLD - 1);
            2'b11:   hold_of = CNT_W'(STORE_HOLD - 1);
            2'b10:   hold_of = CNT_W'(LOAD_HOLD - 1);
            default: hold_of = {CNT_W{1'b0}};
        endcase
    endfunction

    function automatic logic is_halt(input logic [1:0] cls);
        is_halt = (cls == 2'b00);
    endfunction

    logic [INSTR_WIDTH-1:0] mem_r [DEPTH];

    state_t                 state_r, next_state_s;
    logic [INSTR_WIDTH-1:0] instruction_r, instruction_s;
    logic [PROG_BITS-1:0]   pc_r, pc_s;
    logic [CNT_W-1:0]       cnt_r, cnt_s;
    logic                   issue_r, issue_s;
    logic                   busy_r, busy_s;
    logic                   done_r, done_s;
    logic                   we_s;

    logic [PROG_BITS-1:0]   next_addr_s;
    logic [INSTR_WIDTH-1:0] word0_s;
    logic [INSTR_WIDTH-1:0] next_word_s;
    logic                   at_end_s;

    assign next_addr_s = pc_r + {{(PROG_BITS-1){1'b0}}, 1'b1};
    assign word0_s     = mem_r[0];
    assign next_word_s = mem_r[next_addr_s];

`ifdef SEQ_LOOP_EN
    // pc+1 wraps naturally to 0, so the end of store is never terminal.
    assign at_end_s = 1'b0;
`else
    assign at_end_s = (pc_r == {PROG_BITS{1'b1}});
`endif

    // Program store write port; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (we_s) begin
            mem_r[prog_addr] <= prog_data;
        end
    end

    // State and registered output update.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r       <= IDLE;
            instruction_r <= {INSTR_WIDTH{1'b0}};
            pc_r          <= {PROG_BITS{1'b0}};
            cnt_r         <= {CNT_W{1'b0}};
            issue_r       <= 1'b0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
        end else begin
            state_r       <= next_state_s;
            instruction_r <= instruction_s;
            pc_r          <= pc_s;
            cnt_r         <= cnt_s;
            issue_r       <= issue_s;
            busy_r        <= busy_s;
            done_r        <= done_s;
        end
    end

    // Next-state and next-output decode.
    always_comb begin
        next_state_s  = state_r;
        instruction_s = instruction_r;
        pc_s          = pc_r;
        cnt_s         = cnt_r;
        issue_s       = 1'b0;
        busy_s        = 1'b0;
        done_s        = 1'b0;
        we_s          = 1'b0;
        case (state_r)
            IDLE: begin
                instruction_s = {INSTR_WIDTH{1'b0}};
                if (start) begin
                    if (is_halt(word0_s[INSTR_WIDTH-1 -: 2])) begin
                        next_state_s = DONE;
                        done_s       = 1'b1;
                    end else begin
                        next_state_s  = RUN;
                        instruction_s = word0_s;
                        pc_s          = {PROG_BITS{1'b0}};
                        cnt_s         = hold_of(word0_s[INSTR_WIDTH-1 -: 2]);
                        issue_s       = 1'b1;
                        busy_s        = 1'b1;
                    end
                end else if (prog_we) begin
                    we_s = 1'b1;
                end else begin
                    we_s = 1'b0;
                end
            end
            RUN: begin
                busy_s = 1'b1;
                // Abort wins over any hold or advance decision.
                if (stop) begin
                    next_state_s  = IDLE;
                    instruction_s = {INSTR_WIDTH{1'b0}};
                    cnt_s         = {CNT_W{1'b0}};
                    busy_s        = 1'b0;
                end else if (cnt_r != {CNT_W{1'b0}}) begin
                    cnt_s = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                end else if (is_halt(next_word_s[INSTR_WIDTH-1 -: 2]) || at_end_s) begin
                    next_state_s  = DONE;
                    instruction_s = {INSTR_WIDTH{1'b0}};
                    cnt_s         = {CNT_W{1'b0}};
                    busy_s        = 1'b0;
                    done_s        = 1'b1;
                end else begin
                    instruction_s = next_word_s;
                    pc_s          = next_addr_s;
                    cnt_s         = hold_of(next_word_s[INSTR_WIDTH-1 -: 2]);
                    issue_s       = 1'b1;
                end
            end
            DONE: begin
                next_state_s  = IDLE;
                instruction_s = {INSTR_WIDTH{1'b0}};
            end
            default: begin
                next_state_s  = IDLE;
                instruction_s = {INSTR_WIDTH{1'b0}};
                cnt_s         = {CNT_W{1'b0}};
            end
        endcase
    end

    assign instruction = instruction_r;
    assign issue       = issue_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign pc          = pc_r;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed self-checking bench for instr_sequencer; adapts its end-of-store
// expectations when SEQ_LOOP_EN is defined.
module tb_instr_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        prog_we;
    logic [3:0]  prog_addr;
    logic [19:0] prog_data;
    logic        start;
    logic        stop;
    logic [19:0] instruction;
    logic        issue;
    logic        busy;
    logic        done;
    logic [3:0]  pc;

    int total = 0;
    int bad   = 0;

    instr_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .prog_we     (prog_we),
        .prog_addr   (prog_addr),
        .prog_data   (prog_data),
        .start       (start),
        .stop        (stop),
        .instruction (instruction),
        .issue       (issue),
        .busy        (busy),
        .done        (done),
        .pc          (pc)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic prog(input logic [3:0] a, input logic [19:0] d);
        prog_we   = 1'b1;
        prog_addr = a;
        prog_data = d;
        tick();
        prog_we   = 1'b0;
    endtask

    task automatic kick();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        logic [19:0] seq3 [3];
        int n_issue;
        int n_busy;
        int n_done;
        seq3[0] = 20'h47000;
        seq3[1] = 20'h53000;
        seq3[2] = 20'h72001;

        rst = 1'b0; prog_we = 1'b0; prog_addr = 4'd0; prog_data = 20'h0;
        start = 1'b0; stop = 1'b0;
        tick();
        tick();
        chk("rst_instr", instruction, 20'h0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_issue", issue, 1'b0);
        chk("rst_pc", pc, 4'd0);
        rst = 1'b1;
        tick();

        // three ALU words then halt
        prog(4'd0, 20'h47000);
        prog(4'd1, 20'h53000);
        prog(4'd2, 20'h72001);
        prog(4'd3, 20'h00000);
        chk("idle_instr", instruction, 20'h0);
        kick();
        n_issue = 0; n_busy = 0; n_done = 0;
        for (int c = 0; c < 15; c++) begin
            if (issue) n_issue++;
            if (busy) n_busy++;
            if (done) n_done++;
            if (c < 12) chk("seq_instr", instruction, seq3[c / 4]);
            if (c == 4) chk("seq_pc1", pc, 4'd1);
            if (c == 12) chk("seq_done", done, 1'b1);
            if (c == 12) chk("seq_done_instr", instruction, 20'h0);
            tick();
        end
        chk("seq_issues", n_issue, 3);
        chk("seq_busy", n_busy, 12);
        chk("seq_dones", n_done, 1);

        // store then load
        prog(4'd0, 20'hD80F0);
        prog(4'd1, 20'hB80F0);
        prog(4'd2, 20'h00000);
        kick();
        for (int c = 0; c < 9; c++) begin
            if (c < 3) chk("sl_store", instruction, 20'hD80F0);
            else if (c < 7) chk("sl_load", instruction, 20'hB80F0);
            else if (c == 7) chk("sl_done", done, 1'b1);
            else chk("sl_idle", done, 1'b0);
            if (c == 0 || c == 3) chk("sl_issue", issue, 1'b1);
            if (c == 1 || c == 4) chk("sl_noissue", issue, 1'b0);
            tick();
        end

        // halt in word 0, low bits set; write with start high is ignored
        prog(4'd0, 20'h00005);
        prog_we = 1'b1; prog_addr = 4'd0; prog_data = 20'h47000;
        kick();
        prog_we = 1'b0;
        chk("halt_done", done, 1'b1);
        chk("halt_issue", issue, 1'b0);
        chk("halt_instr", instruction, 20'h0);
        chk("halt_busy", busy, 1'b0);
        tick();
        chk("halt_done_off", done, 1'b0);
        kick();
        chk("wr_start_ignored", done, 1'b1);
        tick();

        // stop during second cycle of 0x47000
        prog(4'd0, 20'h47000);
        prog(4'd1, 20'h53000);
        prog(4'd2, 20'h72001);
        prog(4'd3, 20'h00000);
        kick();
        tick();
        chk("stop_pre", instruction, 20'h47000);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("stop_instr", instruction, 20'h0);
        chk("stop_busy", busy, 1'b0);
        n_done = 0;
        for (int c = 0; c < 14; c++) begin
            if (done) n_done++;
            tick();
        end
        chk("stop_nodone", n_done, 0);
        kick();
        chk("restart_pc", pc, 4'd0);
        chk("restart_instr", instruction, 20'h47000);
        chk("restart_issue", issue, 1'b1);

        // write while busy is ignored; then async reset mid-instruction
        prog(4'd1, 20'h12345);
        tick();
        rst = 1'b0;
        #1;
        chk("arst_instr", instruction, 20'h0);
        chk("arst_busy", busy, 1'b0);
        chk("arst_pc", pc, 4'd0);
        chk("arst_issue", issue, 1'b0);
        chk("arst_done", done, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        kick();
        for (int c = 0; c < 4; c++) tick();
        chk("busy_write_kept", instruction, 20'h53000);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        tick();

        // fill the whole store with ALU words
        for (int a = 0; a < 16; a++) prog(4'(a), 20'h47000);
        kick();
        n_busy = 0;
        for (int c = 0; c < 64; c++) begin
            if (busy) n_busy++;
            if (c == 60) chk("full_pc15", pc, 4'd15);
            tick();
        end
        chk("full_busy", n_busy, 64);
`ifdef SEQ_LOOP_EN
        chk("loop_pc0", pc, 4'd0);
        chk("loop_issue", issue, 1'b1);
        chk("loop_busy", busy, 1'b1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("loop_stop_busy", busy, 1'b0);
        chk("loop_stop_done", done, 1'b0);
`else
        chk("full_done", done, 1'b1);
        chk("full_busy_low", busy, 1'b0);
        chk("full_instr", instruction, 20'h0);
        tick();
        chk("full_done_off", done, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
